// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between pipeline, arbiter and unified memory.
// Buses are [31:0]; MSB-first bit 0 of the memory map is bit 31 here.
interface mem_port_arbiter_if;
  logic        iReq_in;
  logic [31:0] iAddr_in;
  logic [31:0] iData_out;
  logic        iReady_out;
  logic        iStall_out;

  logic        dReq_in;
  logic        dWrite_in;
  logic [31:0] dAddr_in;
  logic [31:0] dWData_in;
  logic [1:0]  DSize_in;
  logic        loadSign_in;
  logic [31:0] dData_out;
  logic        dReady_out;
  logic        dAlignErr_out;
  logic        dStall_out;

  logic        memEn_out;
  logic        memWrite_out;
  logic [31:0] memAddr_out;
  logic [3:0]  memBE_out;
  logic [31:0] memWData_out;
  logic [31:0] memRData_in;

  modport slave (
    input  iReq_in, iAddr_in,
    output iData_out, iReady_out, iStall_out,
    input  dReq_in, dWrite_in, dAddr_in,
    input  dWData_in, DSize_in, loadSign_in,
    output dData_out, dReady_out,
    output dAlignErr_out, dStall_out,
    output memEn_out, memWrite_out, memAddr_out,
    output memBE_out, memWData_out,
    input  memRData_in
  );

  modport master (
    output iReq_in, iAddr_in,
    input  iData_out, iReady_out, iStall_out,
    output dReq_in, dWrite_in, dAddr_in,
    output dWData_in, DSize_in, loadSign_in,
    input  dData_out, dReady_out,
    input  dAlignErr_out, dStall_out,
    input  memEn_out, memWrite_out, memAddr_out,
    input  memBE_out, memWData_out,
    output memRData_in
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin I/D arbiter for a single-port unified memory.
// Handles store byte lanes, load alignment and misalignment.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IACC,
    S_DACC,
    S_DONE
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic        lastD_q, lastD_d;
  logic        gntD_q, gntD_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;

  logic        gD, gI;
  logic        mis;
  logic [3:0]  st_be;
  logic [31:0] st_wd;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld;
  logic        acc, done;

  // D wins a tie unless it had the previous grant
  assign gD = bus.dReq_in & (~bus.iReq_in | ~lastD_q);
  assign gI = bus.iReq_in & ~gD;

  always_comb begin
    st_be = 4'b1111;
    st_wd = bus.dWData_in;
    mis   = 1'b0;
    unique case (bus.DSize_in)
      2'b00: begin
        st_wd = {4{bus.dWData_in[7:0]}};
        st_be = 4'b1000 >> bus.dAddr_in[1:0];
      end
      2'b01: begin
        st_wd = {2{bus.dWData_in[15:0]}};
        st_be = bus.dAddr_in[1] ? 4'b0011 : 4'b1100;
        mis   = bus.dAddr_in[0];
      end
      default: mis = |bus.dAddr_in[1:0];
    endcase
    if (!bus.dWrite_in) st_be = 4'b1111;
  end

  always_comb begin
    ld_b = 8'h00;
    unique case (addr_q[1:0])
      2'd0: ld_b = bus.memRData_in[31:24];
      2'd1: ld_b = bus.memRData_in[23:16];
      2'd2: ld_b = bus.memRData_in[15:8];
      default: ld_b = bus.memRData_in[7:0];
    endcase
    ld_h = addr_q[1] ? bus.memRData_in[15:0]
                     : bus.memRData_in[31:16];
    unique case (size_q)
      2'b00: ld = {{24{sign_q & ld_b[7]}}, ld_b};
      2'b01: ld = {{16{sign_q & ld_h[15]}}, ld_h};
      default: ld = bus.memRData_in;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lastD_d = lastD_q;
    gntD_d  = gntD_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    write_d = write_q;
    size_d  = size_q;
    sign_d  = sign_q;
    err_d   = err_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        err_d  = 1'b0;
        data_d = '0;
        unique case (1'b1)
          gD: begin
            lastD_d = 1'b1;
            gntD_d  = 1'b1;
            if (mis) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              addr_d  = bus.dAddr_in;
              be_d    = st_be;
              wdata_d = st_wd;
              write_d = bus.dWrite_in;
              size_d  = bus.DSize_in;
              sign_d  = bus.loadSign_in;
              cnt_d   = LAT_M1;
              state_d = S_DACC;
            end
          end
          gI: begin
            lastD_d = 1'b0;
            gntD_d  = 1'b0;
            addr_d  = bus.iAddr_in;
            be_d    = 4'b1111;
            wdata_d = '0;
            write_d = 1'b0;
            size_d  = 2'b10;
            sign_d  = 1'b0;
            cnt_d   = LAT_M1;
            state_d = S_IACC;
          end
          default: ;
        endcase
      end
      S_IACC, S_DACC: begin
        if (cnt_q == 4'd0) begin
          if (!gntD_q) data_d = bus.memRData_in;
          else         data_d = write_q ? '0 : ld;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lastD_q <= 1'b0;
      gntD_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      lastD_q <= lastD_d;
      gntD_q  <= gntD_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign acc  = (state_q == S_IACC) | (state_q == S_DACC);
  assign done = (state_q == S_DONE);

  assign bus.memEn_out    = acc;
  assign bus.memWrite_out = acc & write_q;
  assign bus.memAddr_out  = {addr_q[31:2], 2'b00};
  assign bus.memBE_out    = acc ? be_q : 4'b0000;
  assign bus.memWData_out = wdata_q;

  assign bus.iReady_out    = done & ~gntD_q;
  assign bus.dReady_out    = done & gntD_q;
  assign bus.iData_out     = bus.iReady_out ? data_q : '0;
  assign bus.dData_out     = bus.dReady_out ? data_q : '0;
  assign bus.dAlignErr_out = bus.dReady_out & err_q;
  assign bus.iStall_out    = bus.iReq_in & ~bus.iReady_out;
  assign bus.dStall_out    = bus.dReq_in & ~bus.dReady_out;

endmodule
